// File: rtl/vram_arbiter.sv
// vram_arbiter: owns the shared video SRAM port and arbitrates
// screen fetch, CPU and aux requesters onto it.
// Ports: clk28/rst; fetch_*, cpu_*, aux_* requester handshakes
// (level req, one-cycle ack); sram_* drive the external SRAM.
module vram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int AUX_MAX_WAIT = 15
) (
  input  logic              clk28,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [7:0]        fetch_data,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_wdata,
  output logic              aux_ack,
  output logic [ADDR_W-1:0] sram_a,
  output logic [7:0]        sram_dout,
  input  logic [7:0]        sram_din,
  output logic              sram_dout_en,
  output logic              n_sram_rd,
  output logic              n_sram_wr
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, WR1, WR2
  } state_t;

  typedef enum logic [1:0] {
    O_NONE, O_FETCH, O_CPU, O_AUX
  } own_t;

  state_t             state;
  own_t               owner;
  own_t               cur;
  own_t               gnt;
  logic [CNT_W-1:0]   aux_cnt;
  logic               decide;
  logic               fetch_el;
  logic               cpu_el;
  logic               aux_el;
  logic               promo;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [7:0]         gnt_wdata;
  logic               gnt_wr;

  // A requester is eligible when its req is up, it is not
  // in its ack cycle (req still held from the old access)
  // and it does not own the access currently in flight.
  always_comb begin
    decide   = (state == IDLE) ||
               (state == RD2) ||
               (state == WR2);
    cur      = (state == IDLE) ? O_NONE : owner;
    fetch_el = fetch_req && !fetch_ack &&
               (cur != O_FETCH);
    cpu_el   = cpu_req && !cpu_ack &&
               (cur != O_CPU);
    aux_el   = aux_req && !aux_ack &&
               (cur != O_AUX);
    promo    = aux_cnt >= CNT_W'(AUX_MAX_WAIT);
    gnt      = O_NONE;
    if (decide) begin
      if (fetch_el)
        gnt = O_FETCH;
      else if (aux_el && promo)
        gnt = O_AUX;
      else if (cpu_el)
        gnt = O_CPU;
      else if (aux_el)
        gnt = O_AUX;
    end
    gnt_addr  = fetch_addr;
    gnt_wdata = cpu_wdata;
    gnt_wr    = 1'b0;
    unique case (gnt)
      O_CPU: begin
        gnt_addr = cpu_addr;
        gnt_wr   = cpu_wr;
      end
      O_AUX: begin
        gnt_addr  = aux_addr;
        gnt_wdata = aux_wdata;
        gnt_wr    = 1'b1;
      end
      default: ;
    endcase
    cpu_wait = !rst && cpu_el && (gnt != O_CPU);
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= O_NONE;
      aux_cnt      <= '0;
      sram_a       <= '0;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
      n_sram_rd    <= 1'b1;
      n_sram_wr    <= 1'b1;
      fetch_ack    <= 1'b0;
      cpu_ack      <= 1'b0;
      aux_ack      <= 1'b0;
      fetch_data   <= '0;
      cpu_rdata    <= '0;
    end else begin
      fetch_ack <= 1'b0;
      cpu_ack   <= 1'b0;
      aux_ack   <= 1'b0;

      if (gnt == O_AUX || !aux_el)
        aux_cnt <= '0;
      else if (!promo)
        aux_cnt <= aux_cnt + 1'b1;

      unique case (state)
        IDLE, RD2, WR2: begin
          if (state == RD2) begin
            if (owner == O_FETCH) begin
              fetch_data <= sram_din;
              fetch_ack  <= 1'b1;
            end else begin
              cpu_rdata <= sram_din;
              cpu_ack   <= 1'b1;
            end
          end
          if (state == WR2) begin
            if (owner == O_AUX)
              aux_ack <= 1'b1;
            else
              cpu_ack <= 1'b1;
          end
          // Close the current access; a same-edge grant
          // below reopens the port back-to-back.
          n_sram_rd    <= 1'b1;
          n_sram_wr    <= 1'b1;
          sram_dout_en <= 1'b0;
          owner        <= gnt;
          state        <= IDLE;
          if (gnt != O_NONE) begin
            sram_a <= gnt_addr;
            if (gnt_wr) begin
              state        <= WR1;
              sram_dout    <= gnt_wdata;
              sram_dout_en <= 1'b1;
            end else begin
              state     <= RD1;
              n_sram_rd <= 1'b0;
            end
          end
        end
        RD1: state <= RD2;
        WR1: begin
          // Address and data were set up a cycle ago.
          state     <= WR2;
          n_sram_wr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and random requester traffic
// against a cycle-timeline reference model of the arbiter.
module tb_vram_arbiter;

  localparam int AW   = 19;
  localparam int MAXW = 15;
  localparam int F    = 0;
  localparam int C    = 1;
  localparam int A    = 2;

  logic          clk28 = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ack;
  logic [7:0]    fetch_data;
  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait;
  logic          aux_req;
  logic [AW-1:0] aux_addr;
  logic [7:0]    aux_wdata;
  logic          aux_ack;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_dout;
  logic [7:0]    sram_din;
  logic          sram_dout_en;
  logic          n_sram_rd;
  logic          n_sram_wr;

  vram_arbiter #(
    .ADDR_W(AW),
    .AUX_MAX_WAIT(MAXW)
  ) dut (
    .clk28(clk28),
    .rst(rst),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack),
    .fetch_data(fetch_data),
    .cpu_req(cpu_req),
    .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack),
    .cpu_wait(cpu_wait),
    .aux_req(aux_req),
    .aux_addr(aux_addr),
    .aux_wdata(aux_wdata),
    .aux_ack(aux_ack),
    .sram_a(sram_a),
    .sram_dout(sram_dout),
    .sram_din(sram_din),
    .sram_dout_en(sram_dout_en),
    .n_sram_rd(n_sram_rd),
    .n_sram_wr(n_sram_wr)
  );

  always #5 clk28 = ~clk28;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // requester stimulus
  logic          rq [3];
  logic [AW-1:0] ad [3];
  logic [7:0]    wd [3];
  logic          cwr;
  bit            hold [3];
  int            rate [3];
  bit            kick [3];
  logic [AW-1:0] kad [3];
  logic [7:0]    kwd [3];
  logic          kwr;
  logic [7:0]    din;
  int            din_fix;
  bit            rel_rst;

  assign fetch_req  = rq[F];
  assign fetch_addr = ad[F];
  assign cpu_req    = rq[C];
  assign cpu_addr   = ad[C];
  assign cpu_wdata  = wd[C];
  assign cpu_wr     = cwr;
  assign aux_req    = rq[A];
  assign aux_addr   = ad[A];
  assign aux_wdata  = wd[A];
  assign sram_din   = din;

  // reference model: the latest access on the port timeline
  bit            cv;
  int            cg;
  int            cw;
  bit            cwr_m;
  logic [7:0]    cwd;
  int            ack_at [3];
  logic [AW-1:0] e_a;
  logic [7:0]    e_fd;
  logic [7:0]    e_cd;
  int            acnt;

  // observations of the DUT for directed checks
  int o_rd;
  int o_wr;
  int o_wait;
  int o_ack [3];
  int o_ackc [3];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               tag, cyc, obs, exp);
    end
  endtask

  task automatic mreset();
    cv    = 0;
    cg    = 0;
    cw    = 0;
    cwr_m = 0;
    cwd   = '0;
    e_a   = '0;
    e_fd  = '0;
    e_cd  = '0;
    acnt  = 0;
    for (int w = 0; w < 3; w++) ack_at[w] = -100;
  endtask

  task automatic obs_clr();
    o_rd   = 0;
    o_wr   = 0;
    o_wait = 0;
    for (int w = 0; w < 3; w++) begin
      o_ack[w]  = 0;
      o_ackc[w] = -1;
    end
  endtask

  task automatic ask(input int w,
                     input logic [AW-1:0] a,
                     input logic [7:0] d,
                     input logic wr);
    kick[w] = 1;
    kad[w]  = a;
    kwd[w]  = d;
    if (w == C) kwr = wr;
  endtask

  task automatic step();
    bit   pend [3];
    int   g;
    int   d;
    int   occ;
    bit   rdp;
    bit   wrp;
    logic [AW-1:0] ra;
    @(posedge clk28);
    #1;
    cyc++;
    if (rel_rst) begin
      rst     = 1'b0;
      rel_rst = 0;
    end
    for (int w = 0; w < 3; w++) begin
      if (rq[w] && ack_at[w] == cyc - 1 && !hold[w])
        rq[w] = 1'b0;
      else if (kick[w]) begin
        rq[w]   = 1'b1;
        ad[w]   = kad[w];
        wd[w]   = kwd[w];
        if (w == C) cwr = kwr;
        kick[w] = 0;
      end else if (!rq[w] &&
                   int'($urandom_range(99)) < rate[w]) begin
        rq[w] = 1'b1;
        ra    = AW'($urandom);
        ad[w] = ra;
        wd[w] = 8'($urandom);
        if (w == C) cwr = 1'($urandom_range(1));
      end
    end
    din = (din_fix >= 0) ? 8'(din_fix) : 8'($urandom);
    #3;
    if (rst) mreset();
    occ = (cv && cyc >= cg + 1 && cyc <= cg + 2) ? cw : -1;
    for (int w = 0; w < 3; w++)
      pend[w] = !rst && rq[w] && ack_at[w] != cyc &&
                occ != w;
    g = -1;
    if (!rst && (!cv || cyc >= cg + 2)) begin
      if (pend[F]) g = F;
      else if (pend[A] && acnt >= MAXW) g = A;
      else if (pend[C]) g = C;
      else if (pend[A]) g = A;
    end
    d   = cyc - cg;
    rdp = cv && !cwr_m && (d == 1 || d == 2);
    wrp = cv && cwr_m && (d == 1 || d == 2);
    chk("n_sram_rd", 32'(n_sram_rd), 32'(!rdp));
    chk("n_sram_wr", 32'(n_sram_wr), 32'(!(wrp && d == 2)));
    chk("dout_en", 32'(sram_dout_en), 32'(wrp));
    chk("sram_a", 32'(sram_a), 32'(e_a));
    if (wrp) chk("sram_dout", 32'(sram_dout), 32'(cwd));
    chk("fetch_ack", 32'(fetch_ack), 32'(ack_at[F] == cyc));
    chk("cpu_ack", 32'(cpu_ack), 32'(ack_at[C] == cyc));
    chk("aux_ack", 32'(aux_ack), 32'(ack_at[A] == cyc));
    chk("fetch_data", 32'(fetch_data), 32'(e_fd));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(e_cd));
    chk("cpu_wait", 32'(cpu_wait), 32'(pend[C] && g != C));
    chk("strobe_excl", 32'(n_sram_rd | n_sram_wr), 32'(1));
    if (!n_sram_rd) o_rd++;
    if (!n_sram_wr) o_wr++;
    if (cpu_wait) o_wait++;
    if (fetch_ack) begin o_ack[F]++; o_ackc[F] = cyc; end
    if (cpu_ack) begin o_ack[C]++; o_ackc[C] = cyc; end
    if (aux_ack) begin o_ack[A]++; o_ackc[A] = cyc; end
    // read data lands at the end of the second read cycle
    if (cv && !cwr_m && d == 2) begin
      if (cw == F) e_fd = din;
      else e_cd = din;
    end
    if (pend[A] && g != A)
      acnt = (acnt < MAXW) ? acnt + 1 : acnt;
    else
      acnt = 0;
    if (g >= 0) begin
      cv        = 1;
      cg        = cyc;
      cw        = g;
      cwr_m     = (g == A) ? 1'b1 : (g == C) ? cwr : 1'b0;
      cwd       = wd[g];
      e_a       = ad[g];
      ack_at[g] = cyc + 3;
    end
  endtask

  int s;

  initial begin
    rst     = 1'b1;
    cwr     = 1'b0;
    kwr     = 1'b0;
    din     = '0;
    din_fix = -1;
    rel_rst = 0;
    for (int w = 0; w < 3; w++) begin
      rq[w]   = 1'b0;
      ad[w]   = '0;
      wd[w]   = '0;
      hold[w] = 0;
      rate[w] = 0;
      kick[w] = 0;
      kad[w]  = '0;
      kwd[w]  = '0;
    end
    mreset();
    obs_clr();
    repeat (2) @(posedge clk28);
    #2;
    chk("rst_n_rd", 32'(n_sram_rd), 32'(1));
    chk("rst_n_wr", 32'(n_sram_wr), 32'(1));
    chk("rst_sram_a", 32'(sram_a), 32'(0));
    chk("rst_wait", 32'(cpu_wait), 32'(0));
    rel_rst = 1;
    repeat (3) step();

    // single cpu read
    obs_clr();
    din_fix = 'hA5;
    ask(C, 19'h1C123, 8'h00, 1'b0);
    step();
    s = cyc;
    repeat (6) step();
    chk("rd_strobe_len", 32'(o_rd), 32'(2));
    chk("rd_ack_cyc", 32'(o_ackc[C]), 32'(s + 3));
    chk("rd_data", 32'(cpu_rdata), 32'(8'hA5));
    chk("rd_no_wait", 32'(o_wait), 32'(0));
    din_fix = -1;

    // single cpu write
    obs_clr();
    ask(C, 19'h05A5A, 8'h3C, 1'b1);
    step();
    s = cyc;
    repeat (6) step();
    chk("wr_no_rd", 32'(o_rd), 32'(0));
    chk("wr_strobe_len", 32'(o_wr), 32'(1));
    chk("wr_ack_cyc", 32'(o_ackc[C]), 32'(s + 3));

    // fetch and cpu in the same cycle
    obs_clr();
    ask(F, 19'h00400, 8'h00, 1'b0);
    ask(C, 19'h12345, 8'h00, 1'b0);
    step();
    s = cyc;
    repeat (8) step();
    chk("fc_fetch_ack", 32'(o_ackc[F]), 32'(s + 3));
    chk("fc_cpu_ack", 32'(o_ackc[C]), 32'(s + 5));
    chk("fc_wait_len", 32'(o_wait), 32'(2));

    // fetch arriving during WR1 of a cpu write
    obs_clr();
    ask(C, 19'h7FFFF, 8'hE7, 1'b1);
    step();
    s = cyc;
    ask(F, 19'h00001, 8'h00, 1'b0);
    repeat (8) step();
    chk("wf_cpu_ack", 32'(o_ackc[C]), 32'(s + 3));
    chk("wf_fetch_ack", 32'(o_ackc[F]), 32'(s + 5));
    chk("wf_wr_len", 32'(o_wr), 32'(1));
    chk("wf_rd_len", 32'(o_rd), 32'(2));

    // aux promotion under continuous fetch and cpu load
    obs_clr();
    hold[F] = 1;
    hold[C] = 1;
    ask(F, 19'h01000, 8'h00, 1'b0);
    ask(C, 19'h02000, 8'h00, 1'b0);
    ask(A, 19'h3FF00, 8'h5A, 1'b1);
    step();
    s = cyc;
    repeat (30) step();
    chk("promo_ack_cyc", 32'(o_ackc[A]), 32'(s + 21));
    chk("promo_ack_cnt", 32'(o_ack[A]), 32'(1));
    ask(A, 19'h3FF01, 8'hA6, 1'b1);
    repeat (40) step();
    chk("promo_again", 32'(o_ack[A]), 32'(2));
    hold[F] = 0;
    hold[C] = 0;
    repeat (12) step();

    // reset in the middle of a cpu read
    obs_clr();
    ask(C, 19'h0ABCD, 8'h00, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_n_rd", 32'(n_sram_rd), 32'(1));
    chk("mid_rst_a", 32'(sram_a), 32'(0));
    chk("mid_rst_ack", 32'(cpu_ack), 32'(0));
    chk("mid_rst_rdata", 32'(cpu_rdata), 32'(0));
    chk("mid_rst_wait", 32'(cpu_wait), 32'(0));
    mreset();
    repeat (2) step();
    rel_rst = 1;
    step();
    s = cyc;
    repeat (6) step();
    chk("post_rst_ack_cnt", 32'(o_ack[C]), 32'(1));
    chk("post_rst_ack_cyc", 32'(o_ackc[C]), 32'(s + 3));

    // random mixed traffic
    rate[F] = 20;
    rate[C] = 25;
    rate[A] = 15;
    repeat (3000) step();
    rate[F] = 0;
    rate[C] = 0;
    rate[A] = 0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
